// File: rtl/scaled_image_drawer_pkg.sv
// Shared constants and helpers for the scaled, double-buffered image window.
// RGB888 channel layout, colour packing/widening and RAM address sizing.
package scaled_image_drawer_pkg;

  localparam int RGB_BITS = 8;
  localparam int R_MSB    = 23;
  localparam int G_MSB    = 15;
  localparam int B_MSB    = 7;

  function automatic int addr_width(input int img_w, input int img_h, input int dbl);
    return $clog2(img_w * img_h) + dbl;
  endfunction

  // Keeps the top chan_bits of each 8-bit channel, right-aligned as {R,G,B}.
  function automatic logic [23:0] pack_rgb(input logic [23:0] rgb, input int chan_bits);
    logic [23:0] pk_v;
    pk_v = 24'h000000;
    for (int i = 0; i < chan_bits; i++) begin
      pk_v[2*chan_bits + i] = rgb[R_MSB - chan_bits + 1 + i];
      pk_v[chan_bits + i]   = rgb[G_MSB - chan_bits + 1 + i];
      pk_v[i]               = rgb[B_MSB - chan_bits + 1 + i];
    end
    return pk_v;
  endfunction

  function automatic logic [7:0] widen_chan(input logic [7:0] chan, input int chan_bits);
    return chan << (RGB_BITS - chan_bits);
  endfunction

endpackage

// File: rtl/scaled_image_drawer_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// The bank select is carried as the address MSB by the caller.
module frame_bank_ram #(
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and read in the same edge; a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scaled_image_drawer.sv
// Double-buffered image window: raster pixel writes land in the back bank,
// the displayed bank is scanned out magnified and framed by a border.
module scaled_image_drawer
  import scaled_image_drawer_pkg::*;
#(
  parameter int          IMG_W         = 128,
  parameter int          IMG_H         = 128,
  parameter int          SCALE_LOG2    = 1,
  parameter int          ORIGIN_X      = 242,
  parameter int          ORIGIN_Y      = 112,
  parameter int          CHAN_BITS     = 4,
  parameter logic [23:0] BORDER_RGB    = 24'hff0000,
  parameter int          DOUBLE_BUFFER = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  row,
  input  logic [9:0]  column,
  input  logic        frame_start,
  input  logic        buffer_write_enable,
  input  logic [23:0] color_code,
  input  logic        write_restart,
  output logic        buffer_write_ready,
  output logic        write_dropped,
  output logic        displayed_bank,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int PIX    = IMG_W * IMG_H;
  localparam int PIX_AW = $clog2(PIX);
  localparam int AW     = addr_width(IMG_W, IMG_H, DOUBLE_BUFFER);
  localparam int XW     = $clog2(IMG_W);
  localparam int DW     = 3 * CHAN_BITS;

  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(PIX - 1);
  localparam logic [10:0] OX     = 11'(ORIGIN_X);
  localparam logic [10:0] OY     = 11'(ORIGIN_Y);
  localparam logic [10:0] SPAN_X = 11'(IMG_W << SCALE_LOG2);
  localparam logic [10:0] SPAN_Y = 11'(IMG_H << SCALE_LOG2);
  localparam logic [10:0] BX_LO  = 11'(ORIGIN_X - 1);
  localparam logic [10:0] BX_HI  = 11'(ORIGIN_X + (IMG_W << SCALE_LOG2));
  localparam logic [10:0] BY_LO  = 11'(ORIGIN_Y - 1);
  localparam logic [10:0] BY_HI  = 11'(ORIGIN_Y + (IMG_H << SCALE_LOG2));

  logic [PIX_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic              bank_q, bank_d;
  logic              swap_pending_q, swap_pending_d;
  logic              dropped_q, dropped_d;
  logic              ready_q, ready_d;
  logic              frame_valid_q, frame_valid_d;
  logic              s1_valid_q, s1_valid_d;
  logic              in_range_q, in_range_d;
  logic              boundary_q, boundary_d;
  logic [23:0]       rgb_q, rgb_d;

  logic              ram_we_s;
  logic              wr_bank_s;
  logic [AW-1:0]     ram_waddr_s;
  logic [AW-1:0]     ram_raddr_s;
  logic [DW-1:0]     ram_wdata_s;
  logic [DW-1:0]     ram_rdata_s;
  logic [10:0]       dx_s;
  logic [10:0]       dy_s;
  logic [PIX_AW-1:0] pix_raddr_s;

  // Write pointer, drop flag and the deferred bank swap.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    bank_d         = bank_q;
    swap_pending_d = swap_pending_q;
    dropped_d      = dropped_q;
    frame_valid_d  = frame_valid_q;
    ram_we_s       = 1'b0;
    if (write_restart) begin
      wr_ptr_d  = '0;
      dropped_d = 1'b0;
    end else if (buffer_write_enable) begin
      if (swap_pending_q) begin
        dropped_d = 1'b1;
      end else begin
        ram_we_s = 1'b1;
        if (wr_ptr_q == LAST_PIX) begin
          wr_ptr_d = '0;
          if (DOUBLE_BUFFER != 0) begin
            swap_pending_d = 1'b1;
          end else begin
            frame_valid_d = 1'b1;
          end
        end else begin
          wr_ptr_d = wr_ptr_q + PIX_AW'(1);
        end
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // A write completing in this cycle sees swap_pending_q==0, so its swap waits a frame.
    if (frame_start && swap_pending_q) begin
      bank_d         = ~bank_q;
      swap_pending_d = 1'b0;
      frame_valid_d  = 1'b1;
    end else begin
      bank_d = bank_d;
    end
    ready_d     = ~swap_pending_d;
    wr_bank_s   = (DOUBLE_BUFFER != 0) ? ~bank_q : bank_q;
    ram_waddr_s = AW'({wr_bank_s, wr_ptr_q});
    ram_wdata_s = DW'(pack_rgb(color_code, CHAN_BITS));
  end

  // Window geometry, read address and the output colour mux.
  always_comb begin
    dx_s        = {1'b0, column} - OX;
    dy_s        = {2'b00, row} - OY;
    pix_raddr_s = PIX_AW'({dy_s >> SCALE_LOG2, XW'(dx_s >> SCALE_LOG2)});
    ram_raddr_s = AW'({bank_q, pix_raddr_s});
    s1_valid_d  = 1'b1;
    in_range_d  = (dx_s < SPAN_X) && (dy_s < SPAN_Y) && frame_valid_q;
    boundary_d  = ({1'b0, column} == BX_LO) || ({1'b0, column} == BX_HI) ||
                  ({2'b00, row} == BY_LO) || ({2'b00, row} == BY_HI);
    if (!s1_valid_q) begin
      rgb_d = 24'h000000;
    end else if (boundary_q) begin
      rgb_d = BORDER_RGB;
    end else if (in_range_q) begin
      rgb_d = {widen_chan(8'(ram_rdata_s[DW-1 -: CHAN_BITS]), CHAN_BITS),
               widen_chan(8'(ram_rdata_s[2*CHAN_BITS-1 -: CHAN_BITS]), CHAN_BITS),
               widen_chan(8'(ram_rdata_s[CHAN_BITS-1:0]), CHAN_BITS)};
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // All state, synchronous active-low reset; RAM contents are left alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      bank_q         <= 1'b0;
      swap_pending_q <= 1'b0;
      dropped_q      <= 1'b0;
      ready_q        <= 1'b1;
      frame_valid_q  <= 1'b0;
      s1_valid_q     <= 1'b0;
      in_range_q     <= 1'b0;
      boundary_q     <= 1'b0;
      rgb_q          <= 24'h000000;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      bank_q         <= bank_d;
      swap_pending_q <= swap_pending_d;
      dropped_q      <= dropped_d;
      ready_q        <= ready_d;
      frame_valid_q  <= frame_valid_d;
      s1_valid_q     <= s1_valid_d;
      in_range_q     <= in_range_d;
      boundary_q     <= boundary_d;
      rgb_q          <= rgb_d;
    end
  end

  frame_bank_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .raddr(ram_raddr_s),
    .rdata(ram_rdata_s)
  );

  assign buffer_write_ready = ready_q;
  assign write_dropped      = dropped_q;
  assign displayed_bank     = bank_q;
  assign red                = rgb_q[23:16];
  assign green              = rgb_q[15:8];
  assign blue               = rgb_q[7:0];

endmodule

// File: tb/tb_scaled_image_drawer.sv
// Directed + randomized bench for scaled_image_drawer against a behavioural
// model of the bank memories, write pointer and window/border geometry.
module tb_scaled_image_drawer;

  localparam int OX   = 242;
  localparam int OY   = 112;
  localparam int W    = 128;
  localparam int NPIX = 16384;
  localparam int SPAN = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  row;
  logic [9:0]  column;
  logic        frame_start;
  logic        buffer_write_enable;
  logic [23:0] color_code;
  logic        write_restart;
  logic        buffer_write_ready;
  logic        write_dropped;
  logic        displayed_bank;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] m_mem [2][NPIX];
  int          m_ptr;
  bit          m_disp, m_pend, m_drop, m_valid;
  logic [23:0] obs_rgb;

  always #5 clk = ~clk;

  scaled_image_drawer #(
    .IMG_W(128), .IMG_H(128), .SCALE_LOG2(1), .ORIGIN_X(242), .ORIGIN_Y(112),
    .CHAN_BITS(4), .BORDER_RGB(24'hff0000), .DOUBLE_BUFFER(1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .row                (row),
    .column             (column),
    .frame_start        (frame_start),
    .buffer_write_enable(buffer_write_enable),
    .color_code         (color_code),
    .write_restart      (write_restart),
    .buffer_write_ready (buffer_write_ready),
    .write_dropped      (write_dropped),
    .displayed_bank     (displayed_bank),
    .red                (red),
    .green              (green),
    .blue               (blue)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pk(input logic [23:0] c);
    return {c[23:20], c[15:12], c[7:4]};
  endfunction

  function automatic logic [23:0] ramp(input int n);
    logic [13:0] v;
    v = 14'(n);
    return {v[11:8], 4'h0, v[7:4], 4'h0, v[3:0], 4'h0};
  endfunction

  // Expected screen colour from the window/border rules and the model memory.
  function automatic logic [23:0] exp_rgb(input int r, input int c);
    int          idx;
    logic [11:0] p;
    if (c == OX - 1 || c == OX + SPAN || r == OY - 1 || r == OY + SPAN) return 24'hff0000;
    if (m_valid && c >= OX && c < OX + SPAN && r >= OY && r < OY + SPAN) begin
      idx = ((r - OY) / 2) * W + (c - OX) / 2;
      p   = m_mem[m_disp][idx];
      return {p[11:8], 4'h0, p[7:4], 4'h0, p[3:0], 4'h0};
    end
    return 24'h000000;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_disp  = 1'b0;
    m_pend  = 1'b0;
    m_drop  = 1'b0;
    m_valid = 1'b0;
  endtask

  // One clock of write-side traffic, followed by a control-output check.
  task automatic cycle(input bit we, input logic [23:0] c, input bit rs, input bit fs);
    bit pend0;
    bit back;
    buffer_write_enable = we;
    color_code          = c;
    write_restart       = rs;
    frame_start         = fs;
    tick();
    pend0 = m_pend;
    back  = !m_disp;
    if (rs) begin
      m_ptr  = 0;
      m_drop = 1'b0;
    end else if (we) begin
      if (pend0) begin
        m_drop = 1'b1;
      end else begin
        m_mem[back][m_ptr] = pk(c);
        if (m_ptr == NPIX - 1) begin
          m_ptr  = 0;
          m_pend = 1'b1;
        end else begin
          m_ptr++;
        end
      end
    end
    if (fs && pend0) begin
      m_disp  = !m_disp;
      m_pend  = 1'b0;
      m_valid = 1'b1;
    end
    buffer_write_enable = 1'b0;
    write_restart       = 1'b0;
    frame_start         = 1'b0;
    check("ready", 24'(buffer_write_ready), 24'(!m_pend));
    check("dropped", 24'(write_dropped), 24'(m_drop));
    check("bank", 24'(displayed_bank), 24'(m_disp));
  endtask

  task automatic probe(input string tag, input int r, input int c);
    row    = 9'(r);
    column = 10'(c);
    tick();
    tick();
    obs_rgb = {red, green, blue};
    check(tag, obs_rgb, exp_rgb(r, c));
  endtask

  task automatic rand_probes(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      probe("rand_window", int'($urandom_range(100, 380)), int'($urandom_range(230, 510)));
      probe("rand_screen", int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)));
    end
  endtask

  initial begin
    reset               = 1'b0;
    row                 = 9'd0;
    column              = 10'd0;
    frame_start         = 1'b0;
    buffer_write_enable = 1'b0;
    color_code          = 24'h000000;
    write_restart       = 1'b0;
    tick();
    tick();
    model_reset();
    check("rst_rgb", {red, green, blue}, 24'h000000);
    check("rst_ready", 24'(buffer_write_ready), 24'h000001);
    check("rst_bank", 24'(displayed_bank), 24'h000000);
    check("rst_dropped", 24'(write_dropped), 24'h000000);
    reset = 1'b1;

    probe("blank_origin", 112, 242);
    check("blank_origin_lit", obs_rgb, 24'h000000);
    rand_probes(4);

    // Constant frame into bank 1, then swap.
    for (int n = 0; n < NPIX; n++) cycle(1'b1, 24'h123456, 1'b0, 1'b0);
    cycle(1'b0, 24'h000000, 1'b0, 1'b0);
    cycle(1'b0, 24'h000000, 1'b0, 1'b1);
    check("const_bank_lit", 24'(displayed_bank), 24'h000001);
    probe("const_origin", 112, 242);
    check("const_origin_lit", obs_rgb, 24'h103050);

    // Ramp frame into bank 0: checks 2x magnification.
    for (int n = 0; n < NPIX; n++) cycle(1'b1, ramp(n), 1'b0, 1'b0);
    cycle(1'b0, 24'h000000, 1'b0, 1'b1);
    probe("ramp_c242", 112, 242);
    probe("ramp_c243", 112, 243);
    probe("ramp_c244", 112, 244);
    check("ramp_c244_lit", obs_rgb, 24'h000010);
    probe("ramp_r113", 113, 244);
    probe("ramp_r114", 114, 242);
    probe("ramp_last", 367, 497);
    probe("border_left", 200, 241);
    check("border_left_lit", obs_rgb, 24'hff0000);
    probe("border_bottom", 368, 300);
    check("border_bottom_lit", obs_rgb, 24'hff0000);
    probe("outside", 50, 100);
    check("outside_lit", obs_rgb, 24'h000000);
    probe("border_top_far", 111, 900);
    rand_probes(10);

    // Junk writes, restart coinciding with a write, then a random frame.
    for (int n = 0; n < 3; n++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 24'habcdef, 1'b1, 1'b0);
    for (int n = 0; n < NPIX; n++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) cycle(1'b1, 24'hffffff, 1'b0, 1'b0);
    check("drop_ready_lit", 24'(buffer_write_ready), 24'h000000);
    check("drop_flag_lit", 24'(write_dropped), 24'h000001);
    cycle(1'b0, 24'h000000, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) probe("after_drop_px", 112, 242 + 2 * n);
    rand_probes(10);
    cycle(1'b0, 24'h000000, 1'b1, 1'b0);
    check("restart_clears_drop", 24'(write_dropped), 24'h000000);

    // Partial image, then reset mid-operation.
    for (int n = 0; n < 5000; n++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
    check("mid_rst_bank", 24'(displayed_bank), 24'h000000);
    check("mid_rst_ready", 24'(buffer_write_ready), 24'h000001);
    cycle(1'b0, 24'h000000, 1'b0, 1'b1);
    check("no_swap_after_rst", 24'(displayed_bank), 24'h000000);
    probe("blank_after_rst", 112, 242);

    // Full frame whose final write meets frame_start: swap waits a frame.
    for (int n = 0; n < NPIX - 1; n++) cycle(1'b1, 24'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 24'($urandom), 1'b0, 1'b1);
    check("late_swap_bank", 24'(displayed_bank), 24'h000000);
    check("late_swap_ready", 24'(buffer_write_ready), 24'h000000);
    cycle(1'b0, 24'h000000, 1'b0, 1'b1);
    check("late_swap_done", 24'(displayed_bank), 24'h000001);
    probe("final_px0", 112, 242);
    probe("final_px1", 112, 244);
    probe("final_last", 367, 497);
    rand_probes(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
